// File: rtl/lstm_gate_unit.sv
// ---------------------------------------------------------------------------
// lstm_gate_unit
//   One LSTM gate: gateOutput[r] = sigmoid(sum_c Wx[r][c]*x[c] +
//   sum_c Wy[r][c]*y[c] + b[r]) for HIDDEN_SZ neurons, in signed Q(QN).(QM).
//   The weight matrices are swept one column per clock from two external
//   column-organised RAMs with registered read data. A piecewise-linear
//   (PLAN) sigmoid produces the activated vector.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   inputVec                x[colAddressRead_X], one cycle after the address
//   prevOutVec              y[colAddressRead_Y], one cycle after the address
//   weightMemOutput_X/_Y    weight column, slice r = W[r][c]
//   biasVec                 slice r = b[r], held stable while running
//   beginCalc               start pulse (accepted in IDLE or DONE)
//   colAddressRead_X/_Y     column addresses for x / y and their weight RAMs
//   dataReady               gateOutput valid, held until reset or next start
//   gateOutput              slice r = activated neuron r (0 .. 1.0)
// ---------------------------------------------------------------------------

// Per-neuron datapath: two multipliers, accumulator, rescale + bias with
// saturation, then the PLAN sigmoid into the output register.
module lstm_gate_lane #(
   parameter int BITWIDTH = 18,
   parameter int QM       = 11,
   parameter int ACC_W    = 42
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       acc_clr,
   input  logic                       acc_en,
   input  logic                       x_en,
   input  logic                       sat_en,
   input  logic                       out_en,
   input  logic signed [BITWIDTH-1:0] w_x,
   input  logic signed [BITWIDTH-1:0] x_val,
   input  logic signed [BITWIDTH-1:0] w_y,
   input  logic signed [BITWIDTH-1:0] y_val,
   input  logic signed [BITWIDTH-1:0] bias,
   output logic        [BITWIDTH-1:0] gate_out
);
   localparam int PW  = 2 * BITWIDTH;
   localparam int EXT = ACC_W - PW;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (BITWIDTH - 1) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   // PLAN breakpoints and offsets, scaled to QM fractional bits
   localparam logic [BITWIDTH:0]   LIM_SAT = (BITWIDTH + 1)'(5 << QM);         // 5.0
   localparam logic [BITWIDTH:0]   LIM_MID = (BITWIDTH + 1)'((19 << QM) / 8);  // 2.375
   localparam logic [BITWIDTH:0]   LIM_LO  = (BITWIDTH + 1)'(1 << QM);         // 1.0
   localparam logic [BITWIDTH-1:0] ONE     = BITWIDTH'(1 << QM);
   localparam logic [BITWIDTH-1:0] C_HI    = BITWIDTH'((27 << QM) / 32);       // 0.84375
   localparam logic [BITWIDTH-1:0] C_MID   = BITWIDTH'((5 << QM) / 8);         // 0.625
   localparam logic [BITWIDTH-1:0] C_LO    = BITWIDTH'((1 << QM) / 2);         // 0.5

   logic signed [PW-1:0]       prod_x, prod_y;
   logic signed [ACC_W-1:0]    px_ext, py_ext;
   logic signed [ACC_W-1:0]    acc_q, acc_d;
   logic signed [ACC_W-1:0]    shifted, bias_ext, biased;
   logic signed [BITWIDTH-1:0] sat_q, sat_d;
   logic signed [BITWIDTH:0]   s_ext;
   logic        [BITWIDTH:0]   mag;
   logic        [BITWIDTH-1:0] f, gate;
   logic        [BITWIDTH-1:0] gate_q, gate_d;

   assign prod_x = w_x * x_val;
   assign prod_y = w_y * y_val;

   // explicit sign extension keeps the accumulate add purely two's complement
   assign px_ext = x_en ? {{EXT{prod_x[PW-1]}}, prod_x} : '0;
   assign py_ext = {{EXT{prod_y[PW-1]}}, prod_y};

   always_comb begin
      acc_d = acc_q;
      if (acc_clr)
         acc_d = '0;
      else if (acc_en)
         acc_d = acc_q + py_ext + px_ext;
   end

   // Rescale to QM with a truncating arithmetic shift; the accumulator is
   // wide enough that the biased sum never wraps before saturation.
   assign shifted  = acc_q >>> QM;
   assign bias_ext = {{(ACC_W - BITWIDTH){bias[BITWIDTH-1]}}, bias};
   assign biased   = shifted + bias_ext;

   always_comb begin
      sat_d = sat_q;
      if (sat_en) begin
         if (biased > SAT_MAX)
            sat_d = SAT_MAX[BITWIDTH-1:0];
         else if (biased < SAT_MIN)
            sat_d = SAT_MIN[BITWIDTH-1:0];
         else
            sat_d = biased[BITWIDTH-1:0];
      end
   end

   // PLAN sigmoid on |s|; one extra bit so |-2^17| is representable
   assign s_ext = {sat_q[BITWIDTH-1], sat_q};
   assign mag   = s_ext[BITWIDTH] ? -s_ext : s_ext;

   always_comb begin
      f = ONE;
      if (mag >= LIM_SAT)
         f = ONE;
      else if (mag >= LIM_MID)
         f = BITWIDTH'(mag >> 5) + C_HI;
      else if (mag >= LIM_LO)
         f = BITWIDTH'(mag >> 3) + C_MID;
      else
         f = BITWIDTH'(mag >> 2) + C_LO;
   end

   assign gate = s_ext[BITWIDTH] ? (ONE - f) : f;

   always_comb begin
      gate_d = gate_q;
      if (out_en)
         gate_d = gate;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q  <= '0;
         sat_q  <= '0;
         gate_q <= '0;
      end else begin
         acc_q  <= acc_d;
         sat_q  <= sat_d;
         gate_q <= gate_d;
      end
   end

   assign gate_out = gate_q;
endmodule

module lstm_gate_unit #(
   parameter int INPUT_SZ      = 4,
   parameter int HIDDEN_SZ     = 32,
   parameter int QN            = 6,
   parameter int QM            = 11,
   parameter int DSP48_PER_ROW = 2,
   localparam int BITWIDTH       = QN + QM + 1,
   localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ,
   localparam int AX             = $clog2(INPUT_SZ),
   localparam int AY             = $clog2(HIDDEN_SZ)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [BITWIDTH-1:0]       inputVec,
   input  logic [BITWIDTH-1:0]       prevOutVec,
   input  logic [LAYER_BITWIDTH-1:0] weightMemOutput_X,
   input  logic [LAYER_BITWIDTH-1:0] weightMemOutput_Y,
   input  logic [LAYER_BITWIDTH-1:0] biasVec,
   input  logic                      beginCalc,
   output logic [AX-1:0]             colAddressRead_X,
   output logic [AY-1:0]             colAddressRead_Y,
   output logic                      dataReady,
   output logic [LAYER_BITWIDTH-1:0] gateOutput
);
   localparam int ACC_W = 2 * BITWIDTH + AY + 1;

   if (DSP48_PER_ROW != 2) begin : g_bad_dsp
      $error("lstm_gate_unit: only DSP48_PER_ROW == 2 is supported");
   end
   if (INPUT_SZ > HIDDEN_SZ) begin : g_bad_sz
      $error("lstm_gate_unit: INPUT_SZ must not exceed HIDDEN_SZ");
   end

   typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;

   state_t        state_q, state_d;
   logic [AY-1:0] cnt_q, cnt_d;
   logic          vld_q, vld_d;     // RAM data for col_q arrives this cycle
   logic [AY-1:0] col_q, col_d;
   logic [1:0]    fin_q, fin_d;
   logic          ready_q, ready_d;
   logic          acc_clr, sat_en, out_en, x_en;

   // X path stops feeding new columns after INPUT_SZ; the held address is
   // harmless because x_en masks those products.
   assign colAddressRead_Y = cnt_q;
   assign colAddressRead_X = ({1'b0, cnt_q} < (AY + 1)'(INPUT_SZ)) ?
                             cnt_q[AX-1:0] : AX'(INPUT_SZ - 1);
   assign x_en             = ({1'b0, col_q} < (AY + 1)'(INPUT_SZ));
   assign dataReady        = ready_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fin_d   = fin_q;
      ready_d = ready_q;
      vld_d   = (state_q == RUN);
      col_d   = cnt_q;
      acc_clr = 1'b0;
      sat_en  = 1'b0;
      out_en  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (beginCalc) begin
               state_d = RUN;
               cnt_d   = '0;
               ready_d = 1'b0;
               acc_clr = 1'b1;
            end
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AY'(HIDDEN_SZ - 1)) begin
               state_d = FINISH;
               cnt_d   = '0;
               fin_d   = '0;
            end
         end
         FINISH: begin
            // fin 0: last column accumulates; 1: rescale/saturate;
            // 2: sigmoid registered and result flagged
            fin_d = fin_q + 1'b1;
            if (fin_q == 2'd1)
               sat_en = 1'b1;
            if (fin_q == 2'd2) begin
               out_en  = 1'b1;
               ready_d = 1'b1;
               fin_d   = '0;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         col_q   <= '0;
         fin_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         col_q   <= col_d;
         fin_q   <= fin_d;
         ready_q <= ready_d;
      end
   end

   for (genvar r = 0; r < HIDDEN_SZ; r++) begin : g_lane
      lstm_gate_lane #(
         .BITWIDTH (BITWIDTH),
         .QM       (QM),
         .ACC_W    (ACC_W)
      ) u_lane (
         .clock    (clock),
         .reset    (reset),
         .acc_clr  (acc_clr),
         .acc_en   (vld_q),
         .x_en     (x_en),
         .sat_en   (sat_en),
         .out_en   (out_en),
         .w_x      (weightMemOutput_X[r*BITWIDTH +: BITWIDTH]),
         .x_val    (inputVec),
         .w_y      (weightMemOutput_Y[r*BITWIDTH +: BITWIDTH]),
         .y_val    (prevOutVec),
         .bias     (biasVec[r*BITWIDTH +: BITWIDTH]),
         .gate_out (gateOutput[r*BITWIDTH +: BITWIDTH])
      );
   end
endmodule

// File: tb/tb_lstm_gate_unit.sv
// Testbench for lstm_gate_unit: behavioural weight/vector RAMs, directed
// golden cases and randomized cases scored against an arithmetic model.
module tb_lstm_gate_unit;
   localparam int IN  = 4;
   localparam int HID = 32;
   localparam int BW  = 18;
   localparam int LW  = BW * HID;

   logic          clock = 1'b0;
   logic          reset;
   logic [BW-1:0] inputVec, prevOutVec;
   logic [LW-1:0] wmx, wmy, biasVec;
   logic          beginCalc;
   logic [1:0]    addrx;
   logic [4:0]    addry;
   logic          dataReady;
   logic [LW-1:0] gateOutput;

   int wx[IN][HID];
   int wy[HID][HID];
   int xv[IN];
   int yv[HID];
   int bv[HID];
   int expv[HID];
   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   lstm_gate_unit dut (
      .clock             (clock),
      .reset             (reset),
      .inputVec          (inputVec),
      .prevOutVec        (prevOutVec),
      .weightMemOutput_X (wmx),
      .weightMemOutput_Y (wmy),
      .biasVec           (biasVec),
      .beginCalc         (beginCalc),
      .colAddressRead_X  (addrx),
      .colAddressRead_Y  (addry),
      .dataReady         (dataReady),
      .gateOutput        (gateOutput)
   );

   // external RAMs: registered read, data one cycle after the address
   always @(posedge clock) begin
      inputVec   <= xv[addrx][BW-1:0];
      prevOutVec <= yv[addry][BW-1:0];
      for (int r = 0; r < HID; r++) begin
         wmx[r*BW +: BW] <= wx[addrx][r][BW-1:0];
         wmy[r*BW +: BW] <= wy[addry][r][BW-1:0];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int rnd(input int m);
      return int'($urandom_range(2 * m)) - m;
   endfunction

   task automatic pack_bias();
      for (int r = 0; r < HID; r++) biasVec[r*BW +: BW] = bv[r][BW-1:0];
   endtask

   // every element set to a constant (diag-only for wy when diag != 0)
   task automatic load_const(input int wxv, input int wyv, input int diag,
                             input int xc, input int yc, input int bc);
      for (int c = 0; c < HID; c++) begin
         for (int r = 0; r < HID; r++) begin
            if (c < IN) wx[c][r] = wxv;
            wy[c][r] = (diag != 0) ? ((c == r) ? diag : 0) : wyv;
         end
         if (c < IN) xv[c] = xc;
         yv[c] = yc;
         bv[c] = bc;
      end
      pack_bias();
   endtask

   task automatic load_rand(input int wm, input int vm, input int bm);
      for (int c = 0; c < HID; c++) begin
         for (int r = 0; r < HID; r++) begin
            if (c < IN) wx[c][r] = rnd(wm);
            wy[c][r] = rnd(wm);
         end
         if (c < IN) xv[c] = rnd(vm);
         yv[c] = rnd(vm);
         bv[c] = rnd(bm);
      end
      pack_bias();
   endtask

   task automatic exp_const(input int v);
      for (int r = 0; r < HID; r++) expv[r] = v;
   endtask

   // reference: exact dot products, floor divide by 2^11, clamp, PLAN curve
   task automatic model();
      for (int r = 0; r < HID; r++) begin
         longint sum = 0;
         longint t, a, f;
         for (int c = 0; c < HID; c++) sum += longint'(wy[c][r]) * longint'(yv[c]);
         for (int c = 0; c < IN; c++)  sum += longint'(wx[c][r]) * longint'(xv[c]);
         t = (sum >>> 11) + bv[r];
         if (t > 131071)  t = 131071;
         if (t < -131072) t = -131072;
         a = (t < 0) ? -t : t;
         if (a >= 10240)     f = 2048;
         else if (a >= 4864) f = a / 32 + 1728;
         else if (a >= 2048) f = a / 8 + 1280;
         else                f = a / 4 + 1024;
         expv[r] = int'((t < 0) ? 2048 - f : f);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic run(input string tag);
      int n;
      @(negedge clock);
      beginCalc = 1'b1;
      @(posedge clock);
      #1;
      beginCalc = 1'b0;
      chk({tag, " ready_low_after_start"}, 64'(dataReady), 64'd0);
      n = 0;
      while (dataReady !== 1'b1 && n < 100) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk({tag, " latency"}, 64'(n), 64'd35);
      for (int r = 0; r < HID; r++)
         chk($sformatf("%s lane%0d", tag, r), 64'(gateOutput[r*BW +: BW]), 64'(expv[r]));
   endtask

   initial begin
      reset     = 1'b1;
      beginCalc = 1'b0;
      load_const(0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clock);
      #1;
      chk("reset dataReady", 64'(dataReady), 64'd0);
      chk("reset gateOutput", 64'(gateOutput == '0), 64'd1);
      chk("reset addrx", 64'(addrx), 64'd0);
      chk("reset addry", 64'(addry), 64'd0);
      @(negedge clock);
      reset = 1'b0;

      // directed golden values
      load_const(0, 0, 0, 1234, -777, 0);
      exp_const(1024);
      run("zero");

      load_const(2048, 0, 0, 2048, 0, 0);
      for (int c = 0; c < HID; c++) yv[c] = rnd(60000);
      exp_const(1984);
      run("xpath");

      load_const(0, 0, 1024, 0, 2048, 0);
      exp_const(1280);
      run("ydiag");

      load_const(0, 0, 0, 2048, 2048, -2048);
      exp_const(512);
      run("bias_m1");

      load_const(0, 0, 0, 2048, 2048, 10240);
      exp_const(2048);
      run("bias_p5");

      load_const(0, 0, 0, 2048, 2048, -10240);
      exp_const(0);
      run("bias_m5");

      load_const(0, 131071, 0, 0, 131071, 0);
      exp_const(2048);
      run("ysat");

      // abort mid-run with reset
      load_rand(1024, 2048, 8192);
      @(negedge clock);
      beginCalc = 1'b1;
      @(posedge clock);
      #1;
      beginCalc = 1'b0;
      repeat (10) @(posedge clock);
      do_reset();
      #1;
      chk("abort dataReady", 64'(dataReady), 64'd0);
      chk("abort gateOutput", 64'(gateOutput == '0), 64'd1);
      repeat (40) @(posedge clock);
      #1;
      chk("abort idle dataReady", 64'(dataReady), 64'd0);
      chk("abort idle gateOutput", 64'(gateOutput == '0), 64'd1);
      load_rand(1024, 2048, 8192);
      model();
      run("after_abort");

      // back-to-back samples, weights reloaded while in reset
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         reset = 1'b1;
         @(posedge clock);
         #1;
         chk($sformatf("b2b%0d ready_falls", k), 64'(dataReady), 64'd0);
         if (k == 4) load_rand(16384, 32768, 65536);
         else        load_rand(1024, 2048, 8192);
         model();
         @(negedge clock);
         reset = 1'b0;
         run($sformatf("b2b%0d", k));
      end

      // restart from DONE without reset
      load_rand(2048, 2048, 4096);
      model();
      run("restart");
      repeat (5) @(posedge clock);
      #1;
      chk("hold dataReady", 64'(dataReady), 64'd1);
      chk("hold lane0", 64'(gateOutput[BW-1:0]), 64'(expv[0]));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
